nark_pipeline_control: RTL and testbench
========================================

Name: nark_pipeline_control

Overview:
Pipelined control unit for the N-bit NARK core. It consumes the fetched instruction and the execute-stage ALU flags, and drives every datapath control input, each aligned to the stage where that input is used (D/E/M/W). It holds the condition-flag register, evaluates conditional execution in E, and squashes the three wrong-path instructions behind any taken PC write. The datapath has no stall or flush ports, so this block owns all annulment.

Parameters:
BITS, 24, instruction width; fields are packed from the MSB down, BITS >= 16.
SQUASH, 3, number of younger instructions annulled after a taken PC write.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  reset, asynchronous, active-high.
Instr  in  BITS  instruction currently in decode (D).
ALUFlags  in  4  {N,Z,C,V} of the instruction currently in execute (E).
ImmSrc  out  1  D: 0 = data/memory immediate, 1 = branch immediate.
ALUSrc  out  1  E: 1 = ExtImm operand.
ALUControl  out  2  E: 00 ADD, 01 SUB, 10 AND, 11 ORR.
MemWrite  out  1  M: store strobe.
RegWrite  out  1  W: register-file write.
MentoReg  out  1  W: 1 = ReadData, 0 = ALUOut.
PCSrc  out  1  W: 1 = Result loads the PC.

Behaviour:
- Field map (BITS=24, offsets from MSB):
  - Cond[23:20]; Op[19:18]: 00 DP, 01 MEM, 10 BR, 11 NOP.
  - DP fields: I[17], Cmd[16:15], S[14], Rd[13:10].
  - MEM fields: L[17] (1 = load), Rd[13:10].
- Decode (combinational, D):
  - ImmSrc = (Op==10).
  - DP: ALUSrc = I, ALUCtl = Cmd, RegW = 1, FlagW = S.
  - MEM: ALUSrc = 1, ALUCtl = 00, RegW = L, MemW = ~L, MemtoReg = L.
  - BR: ALUSrc = 1, ALUCtl = 00, PCW = 1, RegW = 0.
  - DP or load with Rd==4'hF: PCW = 1.
  - NOP: every write control is 0.
- Pipeline registers:
  - D→E holds {valid, Cond, ALUSrc, ALUCtl, FlagW, RegW, MemW, MemtoReg, PCW}.
  - E→M and M→W hold the gated {RegW, MemW, MemtoReg, PCW}.
- Output timing (instruction in D at cycle t):
  - ImmSrc: cycle t.
  - ALUSrc, ALUControl: t+1.
  - MemWrite: t+2.
  - RegWrite, MentoReg, PCSrc: t+3.
- Condition (E) against flag register F = {N,Z,C,V}:
  - EQ 0000, NE 0001, CS 0010, CC 0011, MI 0100, PL 0101, VS 0110, VC 0111.
  - HI 1000 (C&~Z), LS 1001, GE 1010 (N==V), LT 1011, GT 1100 (~Z&N==V), LE 1101.
  - AL 1110; 1111 = never.
  - CondEx = valid & cond_true.
- Gating:
  - RegW, MemW and PCW move forward into E→M only when CondEx is 1; otherwise they are 0.
  - ALUSrc and ALUControl are driven regardless of CondEx; they are harmless.
- Flags: F <= ALUFlags at the edge ending E when CondEx & FlagW. F changes only at that edge. The instruction right behind a flag-setter sees the new F with no hazard.
- Squash, when CondEx & PCW is true in E at cycle t:
  - The D→E register loads valid = 0 at the end of t.
  - A counter loads SQUASH-1. While it is nonzero, each D→E load has valid = 0 and the counter decrements.
  - Net effect: the instructions in D at t, t+1 and t+2 are annulled. The target enters D at t+3, one cycle after PCSrc is asserted at t+2.
- A squashed entry (valid = 0) never writes a register, memory, the PC or the flags. This holds even if its S bit is set.
- A taken PC write cannot occur while the counter is nonzero, because every instruction in E during that window is invalid.
- Reset (async, mid-operation allowed):
  - Outputs go to 0 immediately: ALUControl = 00; ImmSrc follows Instr combinationally.
  - All valid bits, gated controls, F and the counter are cleared.
  - On the first edge after release, the instruction in D is captured normally.
- Register-data hazards are out of scope; software spaces dependent instructions.

Test Plan:
- Reset: pipeline full of 0xE24400, assert RST mid-cycle → RegWrite, MemWrite, PCSrc and ALUControl read 0 before the next edge; after release, the first output appears 3 cycles later.
- ADD imm S=1 R1, 0xE24400 at t → ImmSrc=0 at t; ALUSrc=1, ALUControl=00 at t+1; MemWrite=0 at t+2; RegWrite=1, MentoReg=0, PCSrc=0 at t+3.
- STR 0xE40000 at t, then LDR 0xE60000 at t+1:
  - STR: MemWrite=1 only at t+2, RegWrite=0 at t+3.
  - LDR: RegWrite=1, MentoReg=1 at t+4.
- SUB S=1 0xE0C000 at t with ALUFlags=0100 at t+1, BEQ 0x080000 at t+1, three ADDs behind it:
  - PCSrc=1 at t+4.
  - The three ADDs produce no RegWrite or MemWrite.
  - An ADD at t+5 gives RegWrite=1 at t+8.
- Same sequence with ALUFlags=0000 → PCSrc stays 0 and all three ADDs write.
- Never condition 0xF24400 with ALUFlags=1111, then BEQ 0x080000 → no RegWrite; F is unchanged, so BEQ with prior Z=0 is not taken. A squashed SUB S=1 also leaves F unchanged.

Source files
------------

// File: rtl/nark_pipeline_control.sv
// nark_pipeline_control: stage-aligned control for the NARK pipeline.
// Decodes the instruction in D, carries its controls through E/M/W, and
// evaluates conditional execution in E against the flag register. After a
// taken PC write it annuls the younger wrong-path instructions.
module nark_pipeline_control #(
  parameter int BITS   = 24,
  parameter int SQUASH = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] Instr,
  input  logic [3:0]      ALUFlags,
  output logic            ImmSrc,
  output logic            ALUSrc,
  output logic [1:0]      ALUControl,
  output logic            MemWrite,
  output logic            RegWrite,
  output logic            MentoReg,
  output logic            PCSrc
);

  localparam int CW = (SQUASH > 1) ? $clog2(SQUASH) : 1;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic       valid;
    cond_e      cond;
    logic       alusrc;
    logic [1:0] aluctl;
    logic       flagw;
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       pcw;
  } de_t;

  typedef struct packed {
    logic regw;
    logic memw;
    logic memtoreg;
    logic pcw;
  } em_t;

  typedef struct packed {
    logic regw;
    logic memtoreg;
    logic pcw;
  } mw_t;

  op_e        op;
  cond_e      cond;
  logic       i_l;
  logic       s_bit;
  logic [1:0] cmd;
  logic [3:0] rd;
  logic       dec_alusrc;
  logic [1:0] dec_aluctl;
  logic       dec_flagw;
  logic       dec_regw;
  logic       dec_memw;
  logic       dec_memtoreg;
  logic       dec_pcw;

  de_t           de_q, de_d;
  em_t           em_q, em_d;
  mw_t           mw_q, mw_d;
  logic [3:0]    f_q, f_d;
  logic [CW-1:0] sq_cnt_q, sq_cnt_d;
  logic          cond_true;
  logic          cond_ex;
  logic          take;

  // Low instruction bits carry operands for the datapath, not control.
  logic instr_unused;
  assign instr_unused = ^Instr[BITS-15:0];

  // Decode the instruction currently in D.
  always_comb begin
    cond         = cond_e'(Instr[BITS-1:BITS-4]);
    op           = op_e'(Instr[BITS-5:BITS-6]);
    i_l          = Instr[BITS-7];
    cmd          = Instr[BITS-8:BITS-9];
    s_bit        = Instr[BITS-10];
    rd           = Instr[BITS-11:BITS-14];
    dec_alusrc   = 1'b0;
    dec_aluctl   = 2'b00;
    dec_flagw    = 1'b0;
    dec_regw     = 1'b0;
    dec_memw     = 1'b0;
    dec_memtoreg = 1'b0;
    dec_pcw      = 1'b0;
    unique case (op)
      OP_DP: begin
        dec_alusrc = i_l;
        dec_aluctl = cmd;
        dec_regw   = 1'b1;
        dec_flagw  = s_bit;
        dec_pcw    = (rd == 4'hF);
      end
      OP_MEM: begin
        dec_alusrc   = 1'b1;
        dec_regw     = i_l;
        dec_memw     = ~i_l;
        dec_memtoreg = i_l;
        dec_pcw      = i_l & (rd == 4'hF);
      end
      OP_BR: begin
        dec_alusrc = 1'b1;
        dec_pcw    = 1'b1;
      end
      default: ;
    endcase
    ImmSrc = (op == OP_BR);
  end

  // Evaluate the condition in E, gate writes, update flags and the squash window.
  always_comb begin
    unique case (de_q.cond)
      COND_EQ: cond_true = f_q[2];
      COND_NE: cond_true = ~f_q[2];
      COND_CS: cond_true = f_q[1];
      COND_CC: cond_true = ~f_q[1];
      COND_MI: cond_true = f_q[3];
      COND_PL: cond_true = ~f_q[3];
      COND_VS: cond_true = f_q[0];
      COND_VC: cond_true = ~f_q[0];
      COND_HI: cond_true = f_q[1] & ~f_q[2];
      COND_LS: cond_true = ~f_q[1] | f_q[2];
      COND_GE: cond_true = (f_q[3] == f_q[0]);
      COND_LT: cond_true = (f_q[3] != f_q[0]);
      COND_GT: cond_true = ~f_q[2] & (f_q[3] == f_q[0]);
      COND_LE: cond_true = f_q[2] | (f_q[3] != f_q[0]);
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
    cond_ex = de_q.valid & cond_true;
    take    = cond_ex & de_q.pcw;

    f_d = (cond_ex & de_q.flagw) ? ALUFlags : f_q;

    em_d.regw     = de_q.regw & cond_ex;
    em_d.memw     = de_q.memw & cond_ex;
    em_d.memtoreg = de_q.memtoreg;
    em_d.pcw      = de_q.pcw & cond_ex;

    mw_d.regw     = em_q.regw;
    mw_d.memtoreg = em_q.memtoreg;
    mw_d.pcw      = em_q.pcw;

    // The instruction in D during the taken cycle is dropped directly; the
    // counter then covers the remaining SQUASH-1 slots.
    sq_cnt_d = sq_cnt_q;
    if (take) begin
      sq_cnt_d = CW'(SQUASH - 1);
    end else if (sq_cnt_q != '0) begin
      sq_cnt_d = sq_cnt_q - CW'(1);
    end

    de_d.valid    = ~take & (sq_cnt_q == '0);
    de_d.cond     = cond;
    de_d.alusrc   = dec_alusrc;
    de_d.aluctl   = dec_aluctl;
    de_d.flagw    = dec_flagw;
    de_d.regw     = dec_regw;
    de_d.memw     = dec_memw;
    de_d.memtoreg = dec_memtoreg;
    de_d.pcw      = dec_pcw;
  end

  // Pipeline registers, flag register and squash counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      de_q     <= '0;
      em_q     <= '0;
      mw_q     <= '0;
      f_q      <= '0;
      sq_cnt_q <= '0;
    end else begin
      de_q     <= de_d;
      em_q     <= em_d;
      mw_q     <= mw_d;
      f_q      <= f_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  assign ALUSrc     = de_q.alusrc;
  assign ALUControl = de_q.aluctl;
  assign MemWrite   = em_q.memw;
  assign RegWrite   = mw_q.regw;
  assign MentoReg   = mw_q.memtoreg;
  assign PCSrc      = mw_q.pcw;

endmodule

// File: tb/tb_nark_pipeline_control.sv
// Scoreboard bench for nark_pipeline_control: each issued instruction pushes
// its per-stage expectations tagged with the cycle they are due; a monitor
// on the falling edge pops and compares them.
module tb_nark_pipeline_control;

  logic        CLK = 1'b0;
  logic        RST;
  logic [23:0] Instr;
  logic [3:0]  ALUFlags;
  logic        ImmSrc, ALUSrc, MemWrite, RegWrite, MentoReg, PCSrc;
  logic [1:0]  ALUControl;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  typedef struct { int cyc; logic imm; } d_exp_t;
  typedef struct { int cyc; logic asrc; logic [1:0] actl; } e_exp_t;
  typedef struct { int cyc; logic memw; } m_exp_t;
  typedef struct { int cyc; logic regw; logic mtr; logic chk_mtr; logic pcs; } w_exp_t;

  d_exp_t dq[$];
  e_exp_t eq[$];
  m_exp_t mq[$];
  w_exp_t wq[$];

  nark_pipeline_control #(.BITS(24), .SQUASH(3)) dut (
    .CLK(CLK), .RST(RST), .Instr(Instr), .ALUFlags(ALUFlags),
    .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MentoReg(MentoReg), .PCSrc(PCSrc)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one instruction for the current cycle and queue what each stage must show.
  task automatic issue(input logic [23:0] ins, input logic [3:0] fl,
                       input logic imm, input logic asrc, input logic [1:0] actl,
                       input logic chke, input logic memw, input logic regw,
                       input logic mtr, input logic pcs);
    Instr    = ins;
    ALUFlags = fl;
    dq.push_back('{cyc, imm});
    if (chke) eq.push_back('{cyc + 1, asrc, actl});
    mq.push_back('{cyc + 2, memw});
    wq.push_back('{cyc + 3, regw, mtr, regw, pcs});
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare every expectation due this cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        d_exp_t d;
        d = dq.pop_front();
        chk1("ImmSrc", ImmSrc, d.imm);
      end
      if (eq.size() > 0 && eq[0].cyc == cyc) begin
        e_exp_t e;
        e = eq.pop_front();
        chk1("ALUSrc", ALUSrc, e.asrc);
        chk2("ALUControl", ALUControl, e.actl);
      end
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
        m_exp_t m;
        m = mq.pop_front();
        chk1("MemWrite", MemWrite, m.memw);
      end
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        w_exp_t w;
        w = wq.pop_front();
        chk1("RegWrite", RegWrite, w.regw);
        chk1("PCSrc", PCSrc, w.pcs);
        if (w.chk_mtr) chk1("MentoReg", MentoReg, w.mtr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST      = 1'b1;
    Instr    = 24'hEC0000;
    ALUFlags = 4'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk1("rst_RegWrite", RegWrite, 1'b0);
    chk1("rst_MemWrite", MemWrite, 1'b0);
    chk1("rst_PCSrc", PCSrc, 1'b0);
    chk1("rst_ALUSrc", ALUSrc, 1'b0);
    chk2("rst_ALUControl", ALUControl, 2'b00);
    chk1("rst_ImmSrc", ImmSrc, 1'b0);
    #2 RST = 1'b0;

    //     instr        flags  imm asrc actl  chke memw regw mtr pcs
    issue(24'hE24400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // ADD imm S R1
    issue(24'hE40000, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // STR
    issue(24'hE60000, 4'hF, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); // LDR
    issue(24'hE0C000, 4'hF, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // SUB S
    issue(24'h080000, 4'h4, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); // BEQ taken
    issue(24'hE0C000, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // squashed SUB S
    issue(24'hE24400, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // squashed
    issue(24'hE24400, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // squashed
    issue(24'hE20400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // target ADD
    issue(24'h020400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // EQ ADD, Z=1
    issue(24'hE0C000, 4'h0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // SUB S
    issue(24'h080000, 4'h0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // BEQ not taken
    issue(24'hE24400, 4'hF, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(24'hE24400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(24'hE24400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(24'hF24400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // never
    issue(24'h080000, 4'hF, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // BEQ, Z still 0
    issue(24'hE24400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(24'hE23C00, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); // ADD R15
    issue(24'hE40000, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // squashed STR
    issue(24'hE60000, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // squashed LDR
    issue(24'hE24400, 4'hF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // squashed ADD S
    issue(24'h120400, 4'hF, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // NE ADD, Z=0
    issue(24'hE1C000, 4'h0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // ORR S
    issue(24'hE30000, 4'h9, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // AND imm
    issue(24'hA20400, 4'h1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // GE true
    issue(24'hB20400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // LT false
    issue(24'h820400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // HI false
    issue(24'h920400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // LS true
    issue(24'h020400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // EQ false
    for (int i = 0; i < 4; i++)
      issue(24'hEC0000, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill the pipeline, then reset in the middle of a cycle.
    Instr = 24'hE24400; @(posedge CLK); #1;
    Instr = 24'hE24400; @(posedge CLK); #1;
    Instr = 24'hE40000; @(posedge CLK); #1;
    Instr = 24'hE1C000; @(posedge CLK); #1;
    chk1("pre_rst_RegWrite", RegWrite, 1'b1);
    chk1("pre_rst_MemWrite", MemWrite, 1'b1);
    chk1("pre_rst_ALUSrc", ALUSrc, 1'b0);
    chk2("pre_rst_ALUControl", ALUControl, 2'b11);
    #2 RST = 1'b1;
    Instr = 24'h080000;
    #1;
    chk1("mid_rst_RegWrite", RegWrite, 1'b0);
    chk1("mid_rst_MemWrite", MemWrite, 1'b0);
    chk1("mid_rst_PCSrc", PCSrc, 1'b0);
    chk1("mid_rst_ALUSrc", ALUSrc, 1'b0);
    chk2("mid_rst_ALUControl", ALUControl, 2'b00);
    chk1("mid_rst_ImmSrc", ImmSrc, 1'b1);
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) wq.push_back('{cyc + k, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 2; k++) mq.push_back('{cyc + k, 1'b0});
    #2 RST = 1'b0;
    issue(24'hE24400, 4'h0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      issue(24'hEC0000, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge CLK);
    #1;

    chk_int("dq_drained", dq.size(), 0);
    chk_int("eq_drained", eq.size(), 0);
    chk_int("mq_drained", mq.size(), 0);
    chk_int("wq_drained", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
